// File: rtl/bubble_sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bubble_sort_pkg
//  Purpose  : Shared state encoding and ordering predicate for the bubble
//             sort engine and its compare-exchange cell.
//  Revision : 1.0  initial release
// ============================================================================
package bubble_sort_pkg;

    // Width that every element is extended to before comparison; elements
    // wider than this are not supported.
    localparam int unsigned CMP_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // True when the pair (a, b) violates the requested order. Equal values
    // are never out of order, which keeps the sort stable.
    function automatic logic out_of_order(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input logic             desc,
        input logic             signed_mode
    );
        logic gt;
        logic lt;
        if (signed_mode) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return desc ? lt : gt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_sort_engine_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : sort_cmp_swap
//  Purpose  : Combinational compare-exchange cell. o_lo goes to the lower
//             index, o_hi to the higher index; they are the inputs exchanged
//             when the pair is out of order.
//  Revision : 1.0  initial release
// ============================================================================
module sort_cmp_swap
    import bubble_sort_pkg::*;
#(
    parameter int W      = 8,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_desc,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi,
    output logic         o_swapped
);

    logic [CMP_W-1:0] w_a_ext;
    logic [CMP_W-1:0] w_b_ext;

    // Sign- or zero-extend so a single wide compare serves both modes.
    generate
        if (SIGNED != 0) begin : g_signed_ext
            assign w_a_ext = CMP_W'($signed(i_a));
            assign w_b_ext = CMP_W'($signed(i_b));
        end else begin : g_unsigned_ext
            assign w_a_ext = CMP_W'(i_a);
            assign w_b_ext = CMP_W'(i_b);
        end
    endgenerate

    assign o_swapped = out_of_order(w_a_ext, w_b_ext, i_desc, SIGNED != 0);
    assign o_lo      = o_swapped ? i_b : i_a;
    assign o_hi      = o_swapped ? i_a : i_b;

endmodule
`default_nettype wire

// File: rtl/bubble_sort_engine.sv
`default_nettype none
// ============================================================================
//  Module   : bubble_sort_engine
//  Purpose  : Streams in N words, bubble-sorts them in place (one
//             compare-exchange per cycle, early exit on a swap-free pass)
//             and streams them back out, reporting the swap count.
//  Revision : 1.0  initial release
// ============================================================================
module bubble_sort_engine
    import bubble_sort_pkg::*;
#(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int SIGNED = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_in_valid,
    output logic                              o_in_ready,
    input  logic [W-1:0]                      i_in_data,
    input  logic                              i_sort,
    input  logic                              i_descend,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_out_valid,
    input  logic                              i_out_ready,
    output logic [W-1:0]                      o_out_data,
    output logic [$clog2(N*(N-1)/2+1)-1:0]    o_swaps
);

    localparam int IW = $clog2(N);
    localparam int SW = $clog2(N*(N-1)/2+1);
    // The load counter must be able to hold N itself.
    localparam int CW = IW + 1;

    state_t          r_state;
    logic [W-1:0]    r_elem [N];
    logic [CW-1:0]   r_load_cnt;
    logic [IW-1:0]   r_j;
    logic [IW-1:0]   r_lim;
    logic [IW-1:0]   r_k;
    logic            r_pass_swap;
    logic            r_desc;
    logic [SW-1:0]   r_swaps;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;

    logic [IW-1:0]   w_j1;
    logic [W-1:0]    w_lo;
    logic [W-1:0]    w_hi;
    logic            w_swapped;

    assign w_j1 = r_j + IW'(1);

    sort_cmp_swap #(
        .W      (W),
        .SIGNED (SIGNED)
    ) u_cmp (
        .i_a       (r_elem[r_j]),
        .i_b       (r_elem[w_j1]),
        .i_desc    (r_desc),
        .o_lo      (w_lo),
        .o_hi      (w_hi),
        .o_swapped (w_swapped)
    );

    // Control FSM, index counters, element bank and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            for (int i = 0; i < N; i++) r_elem[i] <= '0;
            r_load_cnt  <= '0;
            r_j         <= '0;
            r_lim       <= '0;
            r_k         <= '0;
            r_pass_swap <= 1'b0;
            r_desc      <= 1'b0;
            r_swaps     <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // A load can only happen below N, so it never competes
                    // with an accepted sort request.
                    if (i_in_valid && r_in_ready) begin
                        r_elem[r_load_cnt[IW-1:0]] <= i_in_data;
                        r_load_cnt <= r_load_cnt + CW'(1);
                        r_in_ready <= (r_load_cnt + CW'(1)) < CW'(N);
                    end else if (i_sort && (r_load_cnt == CW'(N))) begin
                        r_desc      <= i_descend;
                        r_j         <= '0;
                        r_lim       <= IW'(N - 1);
                        r_pass_swap <= 1'b0;
                        r_swaps     <= '0;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    if (w_swapped) begin
                        r_elem[r_j]  <= w_lo;
                        r_elem[w_j1] <= w_hi;
                        r_swaps      <= r_swaps + SW'(1);
                        r_pass_swap  <= 1'b1;
                    end
                    if (r_j != (r_lim - IW'(1))) begin
                        r_j <= w_j1;
                    end else if ((r_pass_swap || w_swapped) && (r_lim > IW'(1))) begin
                        r_lim       <= r_lim - IW'(1);
                        r_j         <= '0;
                        r_pass_swap <= 1'b0;
                    end else begin
                        r_k         <= '0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_out_valid <= 1'b1;
                        // Element 0 may be rewritten on this very cycle
                        // when the final pass is the single pair (0,1).
                        r_out_data  <= ((r_j == '0) && w_swapped) ? w_lo : r_elem[0];
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (i_out_ready) begin
                        if (r_k == IW'(N - 1)) begin
                            r_load_cnt  <= '0;
                            r_in_ready  <= 1'b1;
                            r_done      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_k        <= r_k + IW'(1);
                            r_out_data <= r_elem[r_k + IW'(1)];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_swaps     = r_swaps;

endmodule
`default_nettype wire

// File: tb/tb_bubble_sort_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bubble_sort_engine
//  Purpose  : Directed self-checking bench for bubble_sort_engine. Instance 0
//             is unsigned (N=4, W=8), instance 1 is the signed variant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bubble_sort_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic       sort      [2];
    logic       descend   [2];
    logic       busy      [2];
    logic       done      [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_data  [2];
    logic [2:0] swaps     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bubble_sort_engine #(.N(4), .W(8), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst),
        .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]), .i_in_data(in_data[0]),
        .i_sort(sort[0]), .i_descend(descend[0]),
        .o_busy(busy[0]), .o_done(done[0]),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]), .o_out_data(out_data[0]),
        .o_swaps(swaps[0])
    );

    bubble_sort_engine #(.N(4), .W(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst),
        .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]), .i_in_data(in_data[1]),
        .i_sort(sort[1]), .i_descend(descend[1]),
        .o_busy(busy[1]), .o_done(done[1]),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]), .o_out_data(out_data[1]),
        .o_swaps(swaps[1])
    );

    // Stimulus helpers: all start and end on a falling edge.
    task automatic load_words(input int d, input logic [7:0] vals [4], input int n);
        for (int i = 0; i < n; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = vals[i];
            @(negedge clk);
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic start_sort(input int d, input logic desc);
        sort[d]    = 1'b1;
        descend[d] = desc;
        @(negedge clk);
        sort[d]    = 1'b0;
    endtask

    task automatic count_busy(input int d, output int cyc);
        cyc = 0;
        while (busy[d] && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic unload_check(input int d, input string nm, input logic [7:0] vals [4], input bit toggle);
        for (int i = 0; i < 4; i++) begin
            if (toggle) begin
                out_ready[d] = 1'b0;
                @(negedge clk);
                n_tests++;
                if (out_valid[d] !== 1'b1 || out_data[d] !== vals[i]) begin
                    n_fail++;
                    $display("FAIL %s hold[%0d]: valid=%b data=%h expected valid=1 data=%h", nm, i, out_valid[d], out_data[d], vals[i]);
                end
            end
            out_ready[d] = 1'b1;
            n_tests++;
            if (out_valid[d] !== 1'b1 || done[d] !== 1'b1 || out_data[d] !== vals[i]) begin
                n_fail++;
                $display("FAIL %s word[%0d]: valid=%b done=%b data=%h expected valid=1 done=1 data=%h",
                         nm, i, out_valid[d], done[d], out_data[d], vals[i]);
            end
            @(negedge clk);
        end
        out_ready[d] = 1'b0;
        n_tests++;
        if (out_valid[d] !== 1'b0 || done[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s back-to-idle: valid=%b done=%b in_ready=%b expected 0 0 1", nm, out_valid[d], done[d], in_ready[d]);
        end
    endtask

    task automatic sort_and_check(input int d, input string nm, input logic [7:0] ld [4], input logic desc,
                                  input int exp_cyc, input logic [2:0] exp_swaps, input logic [7:0] exp_out [4],
                                  input bit toggle);
        int cyc;
        load_words(d, ld, 4);
        n_tests++;
        if (in_ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s in_ready-full: got %b expected 0", nm, in_ready[d]);
        end
        start_sort(d, desc);
        count_busy(d, cyc);
        n_tests++;
        if (cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL %s busy-cycles: got %0d expected %0d", nm, cyc, exp_cyc);
        end
        n_tests++;
        if (swaps[d] !== exp_swaps) begin
            n_fail++;
            $display("FAIL %s swaps: got %0d expected %0d", nm, swaps[d], exp_swaps);
        end
        unload_check(d, nm, exp_out, toggle);
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (in_ready[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0 ||
                out_valid[d] !== 1'b0 || out_data[d] !== 8'h00 || swaps[d] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: rdy=%b busy=%b done=%b ov=%b data=%h swaps=%0d expected 1 0 0 0 00 0",
                         d, in_ready[d], busy[d], done[d], out_valid[d], out_data[d], swaps[d]);
            end
        end
    endtask

    task automatic test_reverse;
        sort_and_check(0, "reverse", '{8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 6, 3'd6, '{8'd1, 8'd2, 8'd3, 8'd4}, 1'b1);
    endtask

    task automatic test_sorted;
        sort_and_check(0, "sorted", '{8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, 3, 3'd0, '{8'd1, 8'd2, 8'd3, 8'd4}, 1'b0);
    endtask

    // 5,9,5,2 descending: only the first pair is out of order, the second
    // pass is swap-free.
    task automatic test_descend;
        sort_and_check(0, "descend", '{8'd5, 8'd9, 8'd5, 8'd2}, 1'b1, 5, 3'd1, '{8'd9, 8'd5, 8'd5, 8'd2}, 1'b1);
    endtask

    task automatic test_signed;
        sort_and_check(1, "signed", '{8'hFF, 8'h01, 8'h80, 8'h00}, 1'b0, 6, 3'd3, '{8'h80, 8'hFF, 8'h00, 8'h01}, 1'b0);
    endtask

    task automatic test_partial_load;
        logic [7:0] v [4];
        int cyc;
        v = '{8'd7, 8'd1, 8'd3, 8'd0};
        load_words(0, v, 3);
        start_sort(0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL partial-ignore: busy=%b in_ready=%b done=%b expected 0 1 0", busy[0], in_ready[0], done[0]);
        end
        in_valid[0] = 1'b1;
        in_data[0]  = v[3];
        @(negedge clk);
        in_valid[0] = 1'b0;
        n_tests++;
        if (in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL partial-fourth: in_ready=%b expected 0", in_ready[0]);
        end
        start_sort(0, 1'b0);
        count_busy(0, cyc);
        n_tests++;
        if (cyc !== 6 || swaps[0] !== 3'd5) begin
            n_fail++;
            $display("FAIL partial-sort: cycles=%0d swaps=%0d expected 6 5", cyc, swaps[0]);
        end
        unload_check(0, "partial", '{8'd0, 8'd1, 8'd3, 8'd7}, 1'b0);
    endtask

    task automatic test_reset_midway;
        logic [7:0] v [4];
        int cyc;
        v = '{8'd4, 8'd3, 8'd2, 8'd1};
        // Reset while sorting.
        load_words(0, v, 4);
        start_sort(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b1 || swaps[0] === 3'd0) begin
            n_fail++;
            $display("FAIL rst-sort-pre: busy=%b swaps=%0d expected busy=1 swaps>0", busy[0], swaps[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || swaps[0] !== 3'd0 || done[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst-sort: busy=%b rdy=%b swaps=%0d done=%b ov=%b expected 0 1 0 0 0",
                     busy[0], in_ready[0], swaps[0], done[0], out_valid[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        // Reset during unload with out_ready toggling.
        load_words(0, v, 4);
        start_sort(0, 1'b0);
        count_busy(0, cyc);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        @(negedge clk);
        out_ready[0] = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid[0] !== 1'b0 || done[0] !== 1'b0 || out_data[0] !== 8'h00 || swaps[0] !== 3'd0 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst-out: ov=%b done=%b data=%h swaps=%0d rdy=%b expected 0 0 00 0 1",
                     out_valid[0], done[0], out_data[0], swaps[0], in_ready[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready[0] = 1'b0;
        // Load count was cleared: a bare sort request must be ignored.
        start_sort(0, 1'b0);
        n_tests++;
        if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst-loadcnt: busy=%b in_ready=%b expected 0 1", busy[0], in_ready[0]);
        end
        sort_and_check(0, "post-reset", '{8'd6, 8'd7, 8'd8, 8'd9}, 1'b0, 3, 3'd0, '{8'd6, 8'd7, 8'd8, 8'd9}, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = 8'h00;
            sort[d]      = 1'b0;
            descend[d]   = 1'b0;
            out_ready[d] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_reverse;
        test_sorted;
        test_descend;
        test_signed;
        test_partial_load;
        test_reset_midway;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
